safe_controller: RTL
====================

# safe_controller

Parametrised successor to the four-digit binary safe. Collects an N-digit PIN from binary switches one digit at a time and compares it against a stored PIN. Counts failed attempts and enforces a timed lockout, and can optionally let the user change the PIN while the safe is open. It sits between the 1 Hz tick divider and the bank of seven-segment decoders, driving display codes, blink enables, attempt LEDs and the lock status.

## Interface
- NUM_DIGITS, 4: PIN length and number of displays driven (2..8).
- MAX_ATTEMPTS, 4: failed entries that trigger lockout; also the LED count (1..8).
- LOCKOUT_TICKS, 9: lockout length in ticks; shown on digit 0 (1..9).
- DEFAULT_PIN, 16'h4321: reset PIN, 4 bits per digit, digit 0 in the LSBs (NUM_DIGITS*4 bits).

Ports (clock and reset first):
- clock  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- tick  in  1  one-clock strobe at 1 Hz from the clock divider.
- switches  in  4  binary digit value.
- action_n  in  1  open/lock/commit button, active-low, already debounced and synchronised.
- save_n  in  1  next-digit button, active-low, already debounced and synchronised.
- disp_codes  out  NUM_DIGITS*5  display code per digit, digit 0 in the LSBs.
- blink  out  NUM_DIGITS  per-digit blank enable.
- locked  out  1  high unless in OPEN or CHANGE.
- lockout  out  1  high in LOCKOUT.
- attempt_leds  out  MAX_ATTEMPTS  thermometer count of failed attempts.

## Operation
- **Reset values:**
  - State ENTRY; cursor 0; all digit buffers 0; fail count 0.
  - Stored PIN = DEFAULT_PIN.
  - disp_codes all 0; blink 0; locked 1; lockout 0; attempt_leds 0.
- **Press detection:** a press is a previous sample of 1 followed by a current sample of 0. Holding a button produces exactly one press.
- **Switch clamping:** a switch value above 9 saturates to 9 when written into a buffer.
- **ENTRY state:**
  - Every clock, the buffer at the cursor follows `switches`.
  - The blink bit at the cursor toggles on each tick; all other blink bits are 0.
  - Save press: cursor advances, wrapping from NUM_DIGITS-1 to 0. The blink bit for the new cursor starts at 0.
  - Action press, all buffers equal the stored PIN: go to OPEN and clear the fail count.
  - Action press, mismatch: fail count increments (saturating at MAX_ATTEMPTS) and the state goes to ERROR.
  - The comparison uses the live buffers, including unsaved digits.
- **ERROR state:**
  - All digits show CODE_DASH.
  - On the next tick: clear the buffers, set cursor to 0, and go to ENTRY. If the fail count equals MAX_ATTEMPTS, go to LOCKOUT instead.
  - Buttons are ignored.
- **LOCKOUT state:**
  - Entry loads the countdown with LOCKOUT_TICKS.
  - Digit 0 shows the countdown value; other digits show 0.
  - Each tick decrements the countdown.
  - A tick that arrives with the countdown at 0 clears the fail count and goes to ENTRY with cleared buffers.
  - All buttons are ignored.
- **OPEN state:**
  - Digit 0 shows CODE_OPEN; all other digits show CODE_BLANK; blink is 0.
  - Action press: clear the buffers, set cursor to 0, go to ENTRY.
- **attempt_leds:** bit i is high when fail count > i.
- **Simultaneous presses:** if action and save are pressed in the same cycle, action wins and the save press is discarded.

## Timing
- Every output is registered and updates on the clock edge after the triggering sample.
- Latency from press detection to output change is 1 clock.
- A tick and a button press in the same cycle are both handled; the blink toggle and the state change apply together.
- The ERROR dwell lasts until the next tick, so it is 1 to 1 s plus 1 clock of tick period.
- Lockout lasts LOCKOUT_TICKS+1 ticks after entering LOCKOUT.
- Asserting reset_n low mid-operation (including LOCKOUT or CHANGE) immediately restores every reset value. A changed PIN is not retained.

## Configuration
- SAFE_PIN_CHANGE_EN defined:
  - A save press in OPEN goes to CHANGE.
  - CHANGE behaves like ENTRY for cursor, blink and switch tracking.
  - An action press in CHANGE writes all buffers to the stored PIN and returns to OPEN.
  - A save press in CHANGE advances the cursor.
- SAFE_PIN_CHANGE_EN undefined: the CHANGE state does not exist, save presses in OPEN are ignored, and the stored PIN is constant at DEFAULT_PIN.

## Structure
- Package `safe_pkg` holds:
  - DISP_W = 5.
  - CODE_DASH = 15, CODE_BLANK = 16, CODE_OPEN = 17.
  - The state enum: ENTRY, ERROR, LOCKOUT, OPEN, CHANGE.
- Sub-module `safe_button_edge` (sample register plus press detection), instantiated once for each of action_n and save_n.

## Test plan
- Reset, enter 1,2,3,4 with save between digits, then action: next clock shows OPEN, locked=0, attempt_leds=0.
- Enter 1,2,3,5 then action: dashes shown and attempt_leds=0001; after the next tick, ENTRY with buffers at 0.
- Four wrong attempts: attempt_leds=1111; after ERROR, lockout=1 and digit 0 counts 9 down to 0; the following tick shows ENTRY with attempt_leds=0; presses during lockout have no effect.
- Save and action pressed in the same cycle while in ENTRY: the comparison happens and the cursor does not advance.
- Switches=12 at the cursor: buffer reads 9. Hold save_n low for 100 clocks: cursor advances once only.
- With SAFE_PIN_CHANGE_EN: from OPEN, press save, enter 7,7,7,7, press action; then lock and enter 7,7,7,7: OPEN. Assert reset_n: PIN reverts to 4321.

Source files
------------

// File: rtl/safe_pkg.sv
// Shared state encoding, display codes and digit helper for the safe controller.
package safe_pkg;

    localparam int unsigned DISP_W = 5;

    localparam logic [DISP_W-1:0] CODE_DASH  = DISP_W'(15);
    localparam logic [DISP_W-1:0] CODE_BLANK = DISP_W'(16);
    localparam logic [DISP_W-1:0] CODE_OPEN  = DISP_W'(17);

    typedef enum logic [2:0] {
        ENTRY,
        ERROR,
        LOCKOUT,
        OPEN,
        CHANGE
    } state_t;

    // Switch values above 9 saturate so every buffer holds a decimal digit.
    function automatic logic [3:0] clamp_digit(input logic [3:0] value);
        return (value > 4'd9) ? 4'd9 : value;
    endfunction

endpackage

// File: rtl/safe_button_edge.sv
// Samples an active-low button and flags the high-to-low transition for one clock.
module safe_button_edge (
    input  logic clock,
    input  logic reset_n,
    input  logic button_n,
    output logic press_c
);

    logic sample_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sample_q <= 1'b1;
        end else begin
            sample_q <= button_n;
        end
    end

    assign press_c = sample_q & ~button_n;

endmodule

// File: rtl/safe_controller.sv
// N-digit PIN safe with failed-attempt lockout and registered display outputs.
// Optional PIN change while open is enabled by defining SAFE_PIN_CHANGE_EN.
module safe_controller
    import safe_pkg::*;
#(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned MAX_ATTEMPTS  = 4,
    parameter int unsigned LOCKOUT_TICKS = 9,
    parameter logic [NUM_DIGITS*4-1:0] DEFAULT_PIN = 16'h4321
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         tick,
    input  logic [3:0]                   switches,
    input  logic                         action_n,
    input  logic                         save_n,
    output logic [NUM_DIGITS*DISP_W-1:0] disp_codes,
    output logic [NUM_DIGITS-1:0]        blink,
    output logic                         locked,
    output logic                         lockout,
    output logic [MAX_ATTEMPTS-1:0]      attempt_leds
);

    localparam int unsigned CUR_W  = $clog2(NUM_DIGITS);
    localparam int unsigned FAIL_W = $clog2(MAX_ATTEMPTS + 1);
    localparam int unsigned CNT_W  = $clog2(LOCKOUT_TICKS + 1);

    localparam logic [CUR_W-1:0]  CUR_LAST = CUR_W'(NUM_DIGITS - 1);
    localparam logic [FAIL_W-1:0] FAIL_MAX = FAIL_W'(MAX_ATTEMPTS);

    state_t                       state_q, state_next;
    logic [CUR_W-1:0]             cursor_q, cursor_next;
    logic [NUM_DIGITS-1:0][3:0]   digits_q, digits_next;
    logic                         blink_on_q, blink_on_next;
    logic [FAIL_W-1:0]            fails_q, fails_next;
    logic [CNT_W-1:0]             count_q, count_next;
    logic                         clear_entry;
    logic [NUM_DIGITS*4-1:0]      stored_pin;

    logic [NUM_DIGITS-1:0][DISP_W-1:0] disp_d;
    logic [NUM_DIGITS-1:0]             blink_d;
    logic                              locked_d;
    logic                              lockout_d;
    logic [MAX_ATTEMPTS-1:0]           leds_d;

    logic action_press;
    logic save_press;

    safe_button_edge u_action_edge (
        .clock    (clock),
        .reset_n  (reset_n),
        .button_n (action_n),
        .press_c  (action_press)
    );

    safe_button_edge u_save_edge (
        .clock    (clock),
        .reset_n  (reset_n),
        .button_n (save_n),
        .press_c  (save_press)
    );

`ifdef SAFE_PIN_CHANGE_EN
    logic pin_load;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stored_pin <= DEFAULT_PIN;
        end else if (pin_load) begin
            stored_pin <= digits_next;
        end
    end
`else
    assign stored_pin = DEFAULT_PIN;
`endif

    // State, datapath and output registers; outputs mirror the next-state view.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ENTRY;
            cursor_q     <= '0;
            digits_q     <= '0;
            blink_on_q   <= 1'b0;
            fails_q      <= '0;
            count_q      <= '0;
            disp_codes   <= '0;
            blink        <= '0;
            locked       <= 1'b1;
            lockout      <= 1'b0;
            attempt_leds <= '0;
        end else begin
            state_q      <= state_next;
            cursor_q     <= cursor_next;
            digits_q     <= digits_next;
            blink_on_q   <= blink_on_next;
            fails_q      <= fails_next;
            count_q      <= count_next;
            disp_codes   <= disp_d;
            blink        <= blink_d;
            locked       <= locked_d;
            lockout      <= lockout_d;
            attempt_leds <= leds_d;
        end
    end

    // Next-state and datapath update; action always wins over a same-cycle save.
    always_comb begin
        state_next    = state_q;
        cursor_next   = cursor_q;
        digits_next   = digits_q;
        blink_on_next = blink_on_q;
        fails_next    = fails_q;
        count_next    = count_q;
        clear_entry   = 1'b0;
`ifdef SAFE_PIN_CHANGE_EN
        pin_load      = 1'b0;
`endif
        case (state_q)
            ENTRY, CHANGE: begin
                digits_next[cursor_q] = clamp_digit(switches);
                if (tick) begin
                    blink_on_next = ~blink_on_q;
                end
                if (action_press) begin
`ifdef SAFE_PIN_CHANGE_EN
                    if (state_q == CHANGE) begin
                        pin_load   = 1'b1;
                        state_next = OPEN;
                    end else
`endif
                    if (digits_next == stored_pin) begin
                        state_next = OPEN;
                        fails_next = '0;
                    end else begin
                        state_next = ERROR;
                        if (fails_q != FAIL_MAX) begin
                            fails_next = fails_q + FAIL_W'(1);
                        end
                    end
                end else if (save_press) begin
                    cursor_next   = (cursor_q == CUR_LAST) ? '0 : cursor_q + CUR_W'(1);
                    blink_on_next = 1'b0;
                end
            end
            ERROR: begin
                if (tick) begin
                    clear_entry = 1'b1;
                    if (fails_q == FAIL_MAX) begin
                        state_next = LOCKOUT;
                        count_next = CNT_W'(LOCKOUT_TICKS);
                    end else begin
                        state_next = ENTRY;
                    end
                end
            end
            LOCKOUT: begin
                if (tick) begin
                    if (count_q == '0) begin
                        state_next  = ENTRY;
                        fails_next  = '0;
                        clear_entry = 1'b1;
                    end else begin
                        count_next = count_q - CNT_W'(1);
                    end
                end
            end
            OPEN: begin
                if (action_press) begin
                    state_next  = ENTRY;
                    clear_entry = 1'b1;
                end
`ifdef SAFE_PIN_CHANGE_EN
                else if (save_press) begin
                    state_next  = CHANGE;
                    clear_entry = 1'b1;
                end
`endif
            end
            default: begin
                state_next  = ENTRY;
                clear_entry = 1'b1;
            end
        endcase
        if (clear_entry) begin
            digits_next   = '0;
            cursor_next   = '0;
            blink_on_next = 1'b0;
        end
    end

    // Display, blink and status values for the state being entered.
    always_comb begin
        disp_d    = '0;
        blink_d   = '0;
        locked_d  = 1'b1;
        lockout_d = 1'b0;
        case (state_next)
            ENTRY, CHANGE: begin
                for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                    disp_d[i] = DISP_W'(digits_next[i]);
                end
                blink_d  = NUM_DIGITS'(blink_on_next) << cursor_next;
                locked_d = (state_next == ENTRY);
            end
            ERROR: begin
                for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                    disp_d[i] = CODE_DASH;
                end
            end
            LOCKOUT: begin
                disp_d[0] = DISP_W'(count_next);
                lockout_d = 1'b1;
            end
            OPEN: begin
                for (int unsigned i = 1; i < NUM_DIGITS; i++) begin
                    disp_d[i] = CODE_BLANK;
                end
                disp_d[0] = CODE_OPEN;
                locked_d  = 1'b0;
            end
            default: ;
        endcase
        for (int unsigned i = 0; i < MAX_ATTEMPTS; i++) begin
            leds_d[i] = (fails_next > FAIL_W'(i));
        end
    end

endmodule
